// File: rtl/part4_mac.sv
`default_nettype none
// ============================================================================
// part4_mac : pipelined, saturating, signed multiply-accumulate unit.
//             Operands are registered, multiplied, carried through MUL_ST
//             product stages, then added into a clamped OUT_W running sum.
// Revision  : 1.0  initial release
// ============================================================================
module part4_mac #(
  parameter int IN_W   = 14,
  parameter int OUT_W  = 28,
  parameter int MUL_ST = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic                    valid_in,
  output logic signed [OUT_W-1:0] f,
  output logic                    valid_out
);

  localparam logic [OUT_W-1:0] c_sat_max = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] c_sat_min = {1'b1, {(OUT_W-1){1'b0}}};

  // Input stage
  logic signed [IN_W-1:0]  a_q, b_q;
  logic                    v0_q;

  // Product pipeline; index MUL_ST-1 feeds the accumulator
  logic signed [OUT_W-1:0] p_q  [MUL_ST];
  logic        [MUL_ST-1:0] pv_q;

  // Accumulator stage
  logic signed [OUT_W-1:0] f_q, f_d;
  logic                    vo_q, vo_d;

  logic signed [OUT_W-1:0] w_a_ext, w_b_ext, w_prod;
  logic        [OUT_W:0]   w_sum;
  logic                    w_ovf;

  always_comb begin
    w_a_ext = {{(OUT_W-IN_W){a_q[IN_W-1]}}, a_q};
    w_b_ext = {{(OUT_W-IN_W){b_q[IN_W-1]}}, b_q};
    w_prod  = w_a_ext * w_b_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      v0_q <= 1'b0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      v0_q <= valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_ST; i++) p_q[i] <= '0;
      pv_q <= '0;
    end else begin
      p_q[0]  <= w_prod;
      pv_q[0] <= v0_q;
      for (int i = 1; i < MUL_ST; i++) begin
        p_q[i]  <= p_q[i-1];
        pv_q[i] <= pv_q[i-1];
      end
    end
  end

  // One guard bit: overflow shows up as the top two sum bits disagreeing,
  // and the guard bit then gives the true sign of the result.
  always_comb begin
    w_sum = {f_q[OUT_W-1], f_q} + {p_q[MUL_ST-1][OUT_W-1], p_q[MUL_ST-1]};
    w_ovf = w_sum[OUT_W] ^ w_sum[OUT_W-1];
    f_d   = f_q;
    vo_d  = 1'b0;
    if (pv_q[MUL_ST-1]) begin
      vo_d = 1'b1;
      if (w_ovf) begin
        f_d = w_sum[OUT_W] ? c_sat_min : c_sat_max;
      end else begin
        f_d = w_sum[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q  <= '0;
      vo_q <= 1'b0;
    end else begin
      f_q  <= f_d;
      vo_q <= vo_d;
    end
  end

  assign f         = f_q;
  assign valid_out = vo_q;

endmodule
`default_nettype wire

// File: tb/tb_part4_mac.sv
`default_nettype none
// ============================================================================
// tb_part4_mac : scoreboard bench for part4_mac; expected f/valid_out entries
//                are queued at drive time and compared three edges later.
// Revision     : 1.0  initial release
// ============================================================================
module tb_part4_mac;

  localparam int IN_W   = 14;
  localparam int OUT_W  = 28;
  localparam int c_lat  = 3;
  localparam int c_max  = 134217727;
  localparam int c_min  = -134217728;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [IN_W-1:0]  a, b;
  logic                    valid_in;
  logic signed [OUT_W-1:0] f;
  logic                    valid_out;

  typedef struct {
    bit    v;
    int    f;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   acc;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  part4_mac #(.IN_W(IN_W), .OUT_W(OUT_W), .MUL_ST(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .f         (f),
    .valid_out (valid_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Drives one cycle, updates the reference accumulator and scoreboard,
  // then compares whatever result is due after this edge.
  task automatic drive(input int ai, input int bi, input bit v, input bit r, input string tag);
    exp_t e;
    longint s;
    a        = IN_W'(ai);
    b        = IN_W'(bi);
    valid_in = v;
    reset    = r;
    if (r) begin
      foreach (sb[i]) begin
        sb[i].v = 1'b0;
        sb[i].f = 0;
      end
      acc = 0;
      e.v = 1'b0;
    end else if (v) begin
      s = longint'(acc) + longint'(ai) * longint'(bi);
      if (s > c_max)      acc = c_max;
      else if (s < c_min) acc = c_min;
      else                acc = int'(s);
      e.v = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.f   = acc;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      check({tag, "_rst_f"}, int'(f), 0);
      check({tag, "_rst_v"}, int'(valid_out), 0);
    end
    if (sb.size() > c_lat) begin
      e = sb.pop_front();
      check({e.tag, "_f"}, int'(f), e.f);
      check({e.tag, "_v"}, int'(valid_out), int'(e.v));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, "idle");
  endtask

  initial begin
    acc      = 0;
    reset    = 1'b1;
    a        = '0;
    b        = '0;
    valid_in = 1'b0;

    // Reset held with valid full-scale operands on the inputs
    drive(8191, 8191, 1'b1, 1'b1, "rst0");
    drive(8191, 8191, 1'b1, 1'b1, "rst1");
    idle(3);

    // Back-to-back accumulation
    drive(3, 4, 1'b1, 1'b0, "acc0");
    drive(-5, 6, 1'b1, 1'b0, "acc1");
    drive(7, -2, 1'b1, 1'b0, "acc2");
    idle(3);

    // Bubble in the middle of the stream must not disturb f
    drive(0, 0, 1'b0, 1'b1, "rst2");
    drive(2, 3, 1'b1, 1'b0, "bub0");
    drive(1000, 1000, 1'b0, 1'b0, "bub1");
    drive(4, 5, 1'b1, 1'b0, "bub2");
    idle(3);

    // Positive saturation and recovery
    drive(0, 0, 1'b0, 1'b1, "rst3");
    drive(8191, 8191, 1'b1, 1'b0, "psat0");
    drive(8191, 8191, 1'b1, 1'b0, "psat1");
    drive(8191, 8191, 1'b1, 1'b0, "psat2");
    drive(-1, 1, 1'b1, 1'b0, "psat3");
    idle(3);

    // Negative saturation
    drive(0, 0, 1'b0, 1'b1, "rst4");
    drive(-8192, 8191, 1'b1, 1'b0, "nsat0");
    drive(-8192, 8191, 1'b1, 1'b0, "nsat1");
    drive(-8192, 8191, 1'b1, 1'b0, "nsat2");
    drive(1, 1, 1'b1, 1'b0, "nsat3");
    idle(3);

    // Largest product, twice, from zero
    drive(0, 0, 1'b0, 1'b1, "rst5");
    drive(-8192, -8192, 1'b1, 1'b0, "ext0");
    drive(-8192, -8192, 1'b1, 1'b0, "ext1");
    idle(3);

    // Reset while products are in flight
    drive(0, 0, 1'b0, 1'b1, "rst6");
    drive(100, 100, 1'b1, 1'b0, "mid0");
    drive(100, 100, 1'b1, 1'b0, "mid1");
    drive(100, 100, 1'b1, 1'b0, "mid2");
    drive(0, 0, 1'b0, 1'b1, "midrst");
    drive(2, 2, 1'b1, 1'b0, "mid3");
    idle(3);

    // Random valid/bubble mix against the reference accumulator
    drive(0, 0, 1'b0, 1'b1, "rst7");
    for (int i = 0; i < 60; i++) begin
      drive(int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192,
            1'($urandom_range(3) != 0), 1'b0, "rnd");
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
